uart_cmd_parser: RTL
====================

Name: uart_cmd_parser

Overview:
Downstream consumer of the UART string receive handler. Takes each completed frame payload (rx_string/rx_length/rx_done) and parses the ASCII command form "K:NNNN" into a key byte plus a 32-bit unsigned value. Scans one byte per clock. Emits a one-cycle valid pulse on success or a one-cycle error pulse with an error code, so control logic can drive registers such as frequency or amplitude words.

Parameters:
MAX_BYTES, 128, maximum accepted payload length in bytes; must be 128 or less, because the input bus is 1024 bits.
MAX_DIGITS, 10, maximum number of digit characters after ':'.

Ports:
sys_clk  input  1  system clock; all logic is on its rising edge.
sys_rst  input  1  synchronous, active-high reset.
rx_string  input  1024  frame payload; byte i is at bits [8i+7:8i].
rx_length  input  8  payload byte count.
rx_done  input  1  one-cycle pulse marking that rx_string/rx_length are valid.
cmd_key  output  8  ASCII key of the last successful command.
cmd_value  output  32  parsed value of the last successful command.
cmd_vld  output  1  one-cycle success pulse.
cmd_err  output  1  one-cycle failure pulse.
err_code  output  3  cause of the last failure.
busy  output  1  high in every state except IDLE.
drop_cnt  output  8  saturating count of rx_done pulses ignored while busy.

Behaviour:
- Reset (synchronous, sys_rst=1):
  - state=IDLE.
  - cmd_key=8'h00, cmd_value=0, cmd_vld=0, cmd_err=0, err_code=0, busy=0, drop_cnt=0.
  - Internal buffer, length, index and accumulator are cleared.
  - Reset asserted mid-parse aborts the parse; no pulse is emitted.
- States: IDLE, KEY, SEP, DIGIT, OK, ERR.
- IDLE:
  - On rx_done=1: latch rx_string into buf and rx_length into len, set idx=0, acc=0, go to KEY.
  - If len is 0, below 3, or above MAX_BYTES, go to ERR with err_code=1 (LEN) instead.
- KEY (idx=0): buf byte 0 must be 'A'..'Z' (8'h41..8'h5A). If so, store it as the pending key and go to SEP; otherwise go to ERR with code 2 (KEY).
- SEP (idx=1): byte must be ':' (8'h3A). If so, go to DIGIT; otherwise go to ERR with code 3 (SEP).
- DIGIT (idx=2..len-1):
  - Byte must be '0'..'9'; otherwise go to ERR with code 4 (DIGIT).
  - acc_next = acc*10 + (byte-8'h30), computed 36 bits wide.
  - If acc_next exceeds 32'hFFFF_FFFF, or the digit count exceeds MAX_DIGITS, go to ERR with code 5 (OVF).
  - After the byte at idx=len-1 is accepted, go to OK.
- idx increments by 1 per clock in KEY/SEP/DIGIT; exactly one byte is examined per cycle.
- OK (one cycle): cmd_vld=1, cmd_key=pending key, cmd_value=acc, then IDLE.
- ERR (one cycle): cmd_err=1, err_code updated, then IDLE.
  - cmd_key and cmd_value keep their previous values on error.
  - err_code holds until the next error.
- Latency: for a good frame of length L, cmd_vld is high in the cycle L+1 clocks after the clock edge that sampled rx_done. An error pulse comes one clock after the offending byte is examined.
- Back-to-back frames:
  - rx_done in any non-IDLE state (including OK/ERR) is ignored and drop_cnt increments, saturating at 255.
  - rx_done in the same cycle as the return to IDLE is not accepted; only rx_done sampled while in IDLE starts a parse.
- Leading zeros are allowed ("A:007" gives 7) but count toward MAX_DIGITS.
- cmd_vld and cmd_err are never high in the same cycle.

Optional Feature:
UART_CMD_HEX_PARSE_EN
- Defined:
  - If bytes 2..3 are "0x" or "0X" and len is at least 5, the value is parsed as hex from idx=4.
  - Hex digits are 0-9, a-f, A-F; acc_next = {acc,4'hd}.
  - More than 8 hex digits, or a non-zero top nibble before the shift, gives OVF (code 5).
  - A non-hex character gives code 4.
  - "K:0x" with no digits (len=4) gives code 1.
- Not defined: "x" is an invalid digit, so "A:0x1F" gives err_code=4.

Test Plan:
- "F:12345", L=7 -> cmd_vld 8 clocks after rx_done; cmd_key=8'h46, cmd_value=32'd12345, no cmd_err.
- "A:4294967295" -> cmd_value=32'hFFFF_FFFF. "A:4294967296" -> cmd_err, err_code=5, cmd_key/cmd_value unchanged.
- Error codes:
  - "f:1" -> err_code=2.
  - "F=1" -> err_code=3.
  - "F:1a" -> err_code=4, cmd_err 4 clocks after rx_done.
  - L=2 -> err_code=1.
  - L=200 -> err_code=1.
- Drops: a second rx_done 3 clocks after the first while parsing "B:99" -> drop_cnt=1, only one cmd_vld, with value 99. Then 300 ignored pulses -> drop_cnt=255.
- sys_rst asserted 2 clocks into "C:123456" -> no cmd_vld or cmd_err; all outputs return to reset values. The next frame "C:5" parses to 5.
- With UART_CMD_HEX_PARSE_EN: "D:0x1F" -> cmd_value=32'h1F; "D:0x123456789" -> err_code=5. Without it: "D:0x1F" -> err_code=4.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
//
// Purpose:
//   Parses a completed UART string payload of the form "K:NNNN" into an ASCII
//   key byte and a 32-bit unsigned value. One payload byte is examined per
//   clock. Success gives a one-cycle cmd_vld pulse; failure gives a one-cycle
//   cmd_err pulse with err_code:
//     1 LEN   payload length below 3 or above MAX_BYTES
//     2 KEY   byte 0 is not 'A'..'Z'
//     3 SEP   byte 1 is not ':'
//     4 DIGIT a value character is not a valid digit
//     5 OVF   value exceeds 32 bits or has too many digits
//
// Optional build macro:
//   UART_CMD_HEX_PARSE_EN - when defined, a value starting with "0x"/"0X"
//   (payload length 5 or more) is parsed as up to 8 hex digits. "K:0x" with
//   no digits reports LEN. Without the macro 'x' is just an invalid digit.
//
// Ports:
//   sys_clk    in   system clock, rising edge
//   sys_rst    in   synchronous active-high reset
//   rx_string  in   [1023:0] payload, byte i at bits [8i+7:8i]
//   rx_length  in   [7:0] payload byte count
//   rx_done    in   one-cycle payload-valid strobe
//   cmd_key    out  [7:0] key of the last successful command
//   cmd_value  out  [31:0] value of the last successful command
//   cmd_vld    out  one-cycle success pulse
//   cmd_err    out  one-cycle failure pulse
//   err_code   out  [2:0] cause of the last failure (holds until next error)
//   busy       out  high whenever the parser is not idle
//   drop_cnt   out  [7:0] saturating count of rx_done pulses ignored while busy
//   dbg_state  out  [2:0] current FSM state encoding
//
// Handshake: rx_done has no ready companion. A strobe is accepted only when
// it is sampled in IDLE; a strobe sampled in any other state (including the
// OK/ERR cycle) is discarded and counted in drop_cnt.
// -----------------------------------------------------------------------------
module uart_cmd_parser #(
   parameter int MAX_BYTES  = 128,  // must not exceed 128 (1024-bit bus)
   parameter int MAX_DIGITS = 10
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   input  logic [1023:0] rx_string,
   input  logic [7:0]    rx_length,
   input  logic          rx_done,
   output logic [7:0]    cmd_key,
   output logic [31:0]   cmd_value,
   output logic          cmd_vld,
   output logic          cmd_err,
   output logic [2:0]    err_code,
   output logic          busy,
   output logic [7:0]    drop_cnt,
   output logic [2:0]    dbg_state
);

   localparam logic [7:0] LP_MAX_LEN      = 8'(MAX_BYTES);
   // Decimal digits start at idx 2, so digit number n sits at idx n+1.
   localparam logic [7:0] LP_DEC_LAST_IDX = 8'(MAX_DIGITS + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_KEY   = 3'd1,
      S_SEP   = 3'd2,
      S_DIGIT = 3'd3,
      S_OK    = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   state_t          r_state;
   state_t          w_next_state;
   logic [1023:0]   r_buf;
   logic [7:0]      r_len;
   logic [7:0]      r_idx;
   logic [31:0]     r_acc;
   logic [7:0]      r_pend_key;
   logic [7:0]      r_cmd_key;
   logic [31:0]     r_cmd_value;
   logic            r_cmd_vld;
   logic            r_cmd_err;
   logic [2:0]      r_err_code;
   logic [7:0]      r_drop_cnt;

   logic [7:0]      w_byte;
   logic            w_is_dec;
   logic [35:0]     w_acc_dec;
   logic            w_len_bad;
   logic            w_dig_skip;
   logic            w_dig_bad;
   logic            w_dig_ovf;
   logic [31:0]     w_dig_acc;
   logic [7:0]      w_next_idx;
   logic [31:0]     w_next_acc;
   logic [2:0]      w_err_code;

   // Byte under examination this cycle.
   assign w_byte    = r_buf[{r_idx[6:0], 3'b000} +: 8];
   assign w_is_dec  = (w_byte >= 8'h30) && (w_byte <= 8'h39);
   // 36 bits is enough to hold (2^32-1)*10+9, so overflow is visible in [35:32].
   assign w_acc_dec = ({4'h0, r_acc} * 36'd10) + {32'h0, w_byte[3:0]};

`ifdef UART_CMD_HEX_PARSE_EN
   logic       r_hex;
   logic       w_hex_prefix;
   logic       w_is_hex;
   logic [3:0] w_hex_nib;

   assign w_hex_prefix = (rx_string[23:16] == 8'h30) &&
                         ((rx_string[31:24] == 8'h78) || (rx_string[31:24] == 8'h58));
   // "K:0x" carries no digits at all, which counts as a length fault.
   assign w_len_bad    = (rx_length < 8'd3) || (rx_length > LP_MAX_LEN) ||
                         (w_hex_prefix && (rx_length == 8'd4));

   always_comb begin
      w_is_hex  = 1'b1;
      w_hex_nib = 4'h0;
      if (w_is_dec) begin
         w_hex_nib = w_byte[3:0];
      end else if (((w_byte >= 8'h41) && (w_byte <= 8'h46)) ||
                   ((w_byte >= 8'h61) && (w_byte <= 8'h66))) begin
         // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15.
         w_hex_nib = w_byte[3:0] + 4'd9;
      end else begin
         w_is_hex = 1'b0;
      end
   end
`else
   assign w_len_bad = (rx_length < 8'd3) || (rx_length > LP_MAX_LEN);
`endif

   // Per-byte verdict for the value field, decimal unless the hex prefix was seen.
   always_comb begin
      w_dig_skip = 1'b0;
      w_dig_bad  = !w_is_dec;
      w_dig_ovf  = (w_acc_dec[35:32] != 4'h0) || (r_idx > LP_DEC_LAST_IDX);
      w_dig_acc  = w_acc_dec[31:0];
`ifdef UART_CMD_HEX_PARSE_EN
      if (r_hex) begin
         w_dig_skip = (r_idx < 8'd4);  // walk over the "0x" bytes one per clock
         w_dig_bad  = !w_is_hex;
         w_dig_ovf  = (r_acc[31:28] != 4'h0) || (r_idx > 8'd11);
         w_dig_acc  = {r_acc[27:0], w_hex_nib};
      end
`endif
   end

   // State register.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and datapath-next logic.
   always_comb begin
      w_next_state = r_state;
      w_next_idx   = r_idx;
      w_next_acc   = r_acc;
      w_err_code   = r_err_code;
      case (r_state)
         S_IDLE: begin
            if (rx_done) begin
               w_next_idx = 8'd0;
               w_next_acc = 32'd0;
               if (w_len_bad) begin
                  w_next_state = S_ERR;
                  w_err_code   = 3'd1;
               end else begin
                  w_next_state = S_KEY;
               end
            end
         end
         S_KEY: begin
            if ((w_byte >= 8'h41) && (w_byte <= 8'h5A)) begin
               w_next_state = S_SEP;
               w_next_idx   = r_idx + 8'd1;
            end else begin
               w_next_state = S_ERR;
               w_err_code   = 3'd2;
            end
         end
         S_SEP: begin
            if (w_byte == 8'h3A) begin
               w_next_state = S_DIGIT;
               w_next_idx   = r_idx + 8'd1;
            end else begin
               w_next_state = S_ERR;
               w_err_code   = 3'd3;
            end
         end
         S_DIGIT: begin
            if (w_dig_skip) begin
               w_next_idx = r_idx + 8'd1;
            end else if (w_dig_bad) begin
               w_next_state = S_ERR;
               w_err_code   = 3'd4;
            end else if (w_dig_ovf) begin
               w_next_state = S_ERR;
               w_err_code   = 3'd5;
            end else begin
               w_next_acc = w_dig_acc;
               if (r_idx == (r_len - 8'd1)) begin
                  w_next_state = S_OK;
               end else begin
                  w_next_idx = r_idx + 8'd1;
               end
            end
         end
         S_OK:    w_next_state = S_IDLE;
         S_ERR:   w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_buf       <= '0;
         r_len       <= 8'd0;
         r_idx       <= 8'd0;
         r_acc       <= 32'd0;
         r_pend_key  <= 8'd0;
         r_cmd_key   <= 8'd0;
         r_cmd_value <= 32'd0;
         r_cmd_vld   <= 1'b0;
         r_cmd_err   <= 1'b0;
         r_err_code  <= 3'd0;
         r_drop_cnt  <= 8'd0;
`ifdef UART_CMD_HEX_PARSE_EN
         r_hex       <= 1'b0;
`endif
      end else begin
         if ((r_state == S_IDLE) && rx_done) begin
            r_buf <= rx_string;
            r_len <= rx_length;
`ifdef UART_CMD_HEX_PARSE_EN
            r_hex <= w_hex_prefix && (rx_length >= 8'd5);
`endif
         end
         r_idx <= w_next_idx;
         r_acc <= w_next_acc;
         if (r_state == S_KEY) begin
            r_pend_key <= w_byte;
         end
         // The success pulse is registered out of OK; the error pulse is
         // registered on entry to ERR, so it lines up with the ERR cycle.
         r_cmd_vld <= (r_state == S_OK);
         if (r_state == S_OK) begin
            r_cmd_key   <= r_pend_key;
            r_cmd_value <= r_acc;
         end
         r_cmd_err <= (w_next_state == S_ERR);
         if (w_next_state == S_ERR) begin
            r_err_code <= w_err_code;
         end
         if (rx_done && (r_state != S_IDLE) && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
      end
   end

   assign cmd_key   = r_cmd_key;
   assign cmd_value = r_cmd_value;
   assign cmd_vld   = r_cmd_vld;
   assign cmd_err   = r_cmd_err;
   assign err_code  = r_err_code;
   assign busy      = (r_state != S_IDLE);
   assign drop_cnt  = r_drop_cnt;
   assign dbg_state = r_state;

endmodule
